// File: rtl/boxcar_trigger_if.sv
// rtl/boxcar_trigger_if.sv - sample stream from the delay line into the boxcar discriminator
interface boxcar_trigger_if #(
    parameter int P_NBITS_DATA = 14
);
    logic                    in_valid;
    logic [P_NBITS_DATA-1:0] qo;
    logic [P_NBITS_DATA-1:0] qn;

    modport master (output in_valid, qo, qn);
    modport slave  (input  in_valid, qo, qn);
endinterface

// File: rtl/boxcar_trigger.sv
// rtl/boxcar_trigger.sv - running-sum window discriminator with holdoff and re-arm
module boxcar_trigger #(
    parameter int P_NBITS_DATA = 14,
    parameter int P_NBITS_ADDR = 8,
    parameter int P_NBITS_SUM  = P_NBITS_DATA + P_NBITS_ADDR,
    parameter int P_NBITS_HOLD = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    flush,
    boxcar_trigger_if.slave         smp,
    input  logic [P_NBITS_SUM-1:0]  thresh,
    input  logic [P_NBITS_HOLD-1:0] holdoff,
    output logic [P_NBITS_SUM-1:0]  sum,
    output logic                    sum_valid,
    output logic                    trig,
    output logic [15:0]             trig_cnt,
    output logic                    err
);
    localparam int W = P_NBITS_SUM + 2;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_LOW = 2'd1;
    localparam logic [1:0] S_ARMED    = 2'd2;
    localparam logic [1:0] S_HOLDOFF  = 2'd3;

    localparam logic [W-1:0]            SUM_MAX  = {2'b00, {P_NBITS_SUM{1'b1}}};
    localparam logic [P_NBITS_HOLD-1:0] HOLD_ONE = {{(P_NBITS_HOLD-1){1'b0}}, 1'b1};

    logic [1:0]              state;
    logic [P_NBITS_HOLD-1:0] hold_cnt;
    logic                    accept;
    logic signed [W-1:0]     nxt_raw;
    logic [P_NBITS_SUM-1:0]  nxt;
    logic                    sat;

    assign accept = smp.in_valid & ~flush;

    // Two guard bits: one for the sign of a net decrease, one for carry past max.
    always_comb begin
        nxt_raw = $signed({2'b00, sum})
                + $signed({{(W-P_NBITS_DATA){1'b0}}, smp.qo})
                - $signed({{(W-P_NBITS_DATA){1'b0}}, smp.qn});
        sat = 1'b0;
        nxt = nxt_raw[P_NBITS_SUM-1:0];
        if (nxt_raw[W-1]) begin
            sat = 1'b1;
            nxt = '0;
        end else if (nxt_raw > $signed(SUM_MAX)) begin
            sat = 1'b1;
            nxt = {P_NBITS_SUM{1'b1}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            sum_valid <= 1'b0;
            trig      <= 1'b0;
            trig_cnt  <= '0;
            err       <= 1'b0;
            state     <= S_IDLE;
            hold_cnt  <= '0;
        end else if (flush) begin
            sum       <= '0;
            sum_valid <= 1'b0;
            trig      <= 1'b0;
            hold_cnt  <= '0;
            state     <= en ? S_WAIT_LOW : S_IDLE;
        end else begin
            sum_valid <= accept;
            trig      <= 1'b0;
            if (accept) begin
                sum <= nxt;
                if (sat) err <= 1'b1;
            end
            if (!en) begin
                state    <= S_IDLE;
                hold_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: state <= S_WAIT_LOW;
                    S_WAIT_LOW: begin
                        if (accept && nxt < thresh) state <= S_ARMED;
                    end
                    S_ARMED: begin
                        if (accept && nxt >= thresh) begin
                            trig     <= 1'b1;
                            trig_cnt <= trig_cnt + 16'd1;
                            if (holdoff == '0) begin
                                state <= S_WAIT_LOW;
                            end else begin
                                hold_cnt <= holdoff;
                                state    <= S_HOLDOFF;
                            end
                        end
                    end
                    default: begin
                        // Holdoff length counts accepted samples, not clock cycles.
                        if (accept) begin
                            if (hold_cnt <= HOLD_ONE) begin
                                hold_cnt <= '0;
                                state    <= S_WAIT_LOW;
                            end else begin
                                hold_cnt <= hold_cnt - HOLD_ONE;
                            end
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_boxcar_trigger.sv
// tb/tb_boxcar_trigger.sv - directed bench with a behavioural window/trigger model
module tb_boxcar_trigger;
    localparam int DW = 14;
    localparam int SW = 22;
    localparam int HW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          flush = 1'b0;
    logic [SW-1:0] thresh = '0;
    logic [HW-1:0] holdoff = '0;
    logic [SW-1:0] sum;
    logic          sum_valid;
    logic          trig;
    logic [15:0]   trig_cnt;
    logic          err;

    int checks = 0;
    int errors = 0;

    boxcar_trigger_if #(.P_NBITS_DATA(DW)) bif ();

    boxcar_trigger dut (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .smp(bif),
        .thresh(thresh), .holdoff(holdoff), .sum(sum), .sum_valid(sum_valid),
        .trig(trig), .trig_cnt(trig_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: window sum with clamping, plus trigger rules stated as
    // "active", "armed" and "samples of holdoff left".
    longint m_sum;
    bit     m_sv, m_trig, m_err, m_active, m_armed;
    int     m_cnt, m_hold_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sum = 0; m_sv = 0; m_trig = 0; m_err = 0; m_cnt = 0;
            m_active = 0; m_armed = 0; m_hold_left = 0;
        end else if (flush) begin
            m_sum = 0; m_sv = 0; m_trig = 0;
            m_active = en; m_armed = 0; m_hold_left = 0;
        end else begin
            bit     acc;
            longint n;
            acc = bif.in_valid;
            m_sv = acc;
            m_trig = 0;
            n = m_sum;
            if (acc) begin
                n = m_sum + longint'(bif.qo) - longint'(bif.qn);
                if (n < 0) begin n = 0; m_err = 1; end
                if (n > (64'd1 << SW) - 1) begin n = (64'd1 << SW) - 1; m_err = 1; end
                m_sum = n;
            end
            if (!en) begin
                m_active = 0; m_armed = 0; m_hold_left = 0;
            end else if (!m_active) begin
                m_active = 1;
            end else if (acc) begin
                if (m_hold_left > 0) begin
                    m_hold_left--;
                end else if (m_armed) begin
                    if (n >= longint'(thresh)) begin
                        m_trig = 1;
                        m_cnt = (m_cnt + 1) & 16'hFFFF;
                        m_armed = 0;
                        m_hold_left = int'(holdoff);
                    end
                end else if (n < longint'(thresh)) begin
                    m_armed = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_sum", longint'(sum), m_sum);
            chk("model_sum_valid", longint'(sum_valid), longint'(m_sv));
            chk("model_trig", longint'(trig), longint'(m_trig));
            chk("model_trig_cnt", longint'(trig_cnt), longint'(m_cnt));
            chk("model_err", longint'(err), longint'(m_err));
        end
    end

    task automatic sample(input int o, input int n);
        bif.in_valid = 1'b1;
        bif.qo = DW'(o);
        bif.qn = DW'(n);
        @(negedge clk);
        bif.in_valid = 1'b0;
    endtask

    task automatic idle(input int cycles);
        bif.in_valid = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic ramp_expect(input string tag, input int s, input int t);
        chk({tag, "_sum"}, longint'(sum), longint'(s));
        chk({tag, "_trig"}, longint'(trig), longint'(t));
    endtask

    initial begin
        bif.in_valid = 1'b0;
        bif.qo = '0;
        bif.qn = '0;
        en = 1'b1;
        thresh = SW'(35);
        holdoff = HW'(2);
        repeat (3) @(negedge clk);
        chk("reset_sum", longint'(sum), 0);
        chk("reset_trig_cnt", longint'(trig_cnt), 0);
        chk("reset_err", longint'(err), 0);
        rst_n = 1'b1;
        idle(1);

        // Ramp-up, holdoff and re-arm
        sample(10, 0);  ramp_expect("ramp1", 10, 0);
        sample(10, 0);  ramp_expect("ramp2", 20, 0);
        sample(10, 0);  ramp_expect("ramp3", 30, 0);
        sample(10, 0);  ramp_expect("ramp4", 40, 1);
        chk("ramp_trig_cnt", longint'(trig_cnt), 1);
        sample(10, 10); ramp_expect("steady1", 40, 0);
        sample(10, 10); ramp_expect("steady2", 40, 0);
        sample(10, 10); ramp_expect("steady3", 40, 0);
        sample(0, 10);  ramp_expect("rearm_low", 30, 0);
        sample(10, 0);  ramp_expect("rearm_high", 40, 1);
        chk("rearm_trig_cnt", longint'(trig_cnt), 2);
        idle(2);

        // Flush collides with a sample
        flush = 1'b1;
        sample(100, 0);
        flush = 1'b0;
        chk("flush_sum", longint'(sum), 0);
        chk("flush_sum_valid", longint'(sum_valid), 0);

        // Underflow saturation and sticky err
        sample(0, 5);
        chk("sat_sum", longint'(sum), 0);
        chk("sat_err", longint'(err), 1);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        chk("err_after_flush", longint'(err), 1);

        // Enable drop during holdoff
        holdoff = HW'(5);
        sample(10, 0); sample(10, 0); sample(10, 0); sample(10, 0);
        chk("en_trig_pre", longint'(trig), 1);
        chk("en_cnt_pre", longint'(trig_cnt), 3);
        en = 1'b0;
        idle(1);
        en = 1'b1;
        idle(1);
        sample(10, 10); ramp_expect("reen_high", 40, 0);
        sample(10, 10); ramp_expect("reen_high2", 40, 0);
        sample(0, 10);  ramp_expect("reen_low", 30, 0);
        sample(10, 0);  ramp_expect("reen_fire", 40, 1);
        chk("reen_cnt", longint'(trig_cnt), 4);

        // Asynchronous reset between clock edges
        bif.in_valid = 1'b1;
        bif.qo = DW'(10);
        bif.qn = DW'(0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_sum", longint'(sum), 0);
        chk("arst_sum_valid", longint'(sum_valid), 0);
        chk("arst_trig_cnt", longint'(trig_cnt), 0);
        chk("arst_err", longint'(err), 0);
        bif.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        sample(10, 0);
        chk("post_rst_sum", longint'(sum), 10);
        chk("post_rst_cnt", longint'(trig_cnt), 0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
